pipelined_adder_tree: RTL

//  Parametrised successor of the fixed 3-operand, 8-bit pipelined adder.

---
 rtl/pipelined_adder_pkg.sv | 17 +
 rtl/pipelined_adder_tree_level.sv | 47 ++++
 rtl/pipelined_adder_tree.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
// Provides the output-mode encodings and a constant ceil-log2.
package pipelined_adder_pkg;

    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_adder_tree_level.sv
// One registered level of the adder tree: pairwise sums, one bit wider.
// An odd trailing element is summed with zero and so passes through.
module adder_tree_level
    import pipelined_adder_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int N_IN = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             v_in,
    input  logic [N_IN*IN_W-1:0]             d_in,
    output logic                             v_out,
    output logic [((N_IN+1)/2)*(IN_W+1)-1:0] d_out
);

    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int OUT_W = IN_W + 1;
    localparam int PAD_W = 2 * N_OUT * IN_W;

    logic [PAD_W-1:0]       d_pad;
    logic [N_OUT*OUT_W-1:0] sums;

    assign d_pad = PAD_W'(d_in);

    always_comb begin
        sums = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sums[i*OUT_W +: OUT_W] =
                OUT_W'(d_pad[2*i*IN_W +: IN_W]) +
                OUT_W'(d_pad[(2*i+1)*IN_W +: IN_W]);
        end
    end

    // Data only loads with a valid element so the tail keeps the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else if (en) begin
            v_out <= v_in;
            if (v_in) d_out <= sums;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Registered binary adder tree over N_OPS operands with valid/ready flow
// control, wrap or saturate result, overflow flag and full-precision sum.
module pipelined_adder_tree
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_OPS    = 3,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_OPS*WIDTH-1:0]       ops,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             z,
    output logic [WIDTH+clog2(N_OPS)-1:0] z_full,
    output logic                         ovf
);

    localparam int LVL = clog2(N_OPS);
    localparam int FW  = WIDTH + LVL;

    logic          en;
    logic          v_last;
    logic [FW-1:0] sum_last;

    // One shared enable: the whole pipe moves or the whole pipe holds.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    generate
        if (LVL == 0) begin : g_single
            logic          v_r;
            logic [FW-1:0] d_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    d_r <= '0;
                end else if (en) begin
                    v_r <= in_valid;
                    if (in_valid) d_r <= ops;
                end
            end

            assign v_last   = v_r;
            assign sum_last = d_r;
        end else begin : g_tree
            for (genvar k = 1; k <= LVL; k++) begin : g_lvl
                localparam int IN_W  = WIDTH + k - 1;
                localparam int N_IN  =
                    (N_OPS + (1 << (k - 1)) - 1) >> (k - 1);
                localparam int N_OUT = (N_IN + 1) / 2;

                logic                       v_i;
                logic [N_IN*IN_W-1:0]       d_i;
                logic                       v_o;
                logic [N_OUT*(IN_W+1)-1:0]  d_o;

                if (k == 1) begin : g_first
                    assign v_i = in_valid;
                    assign d_i = ops;
                end else begin : g_next
                    assign v_i = g_lvl[k-1].v_o;
                    assign d_i = g_lvl[k-1].d_o;
                end

                adder_tree_level #(
                    .IN_W (IN_W),
                    .N_IN (N_IN)
                ) u_level (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (en),
                    .v_in  (v_i),
                    .d_in  (d_i),
                    .v_out (v_o),
                    .d_out (d_o)
                );

                if (k == LVL) begin : g_last
                    assign v_last   = v_o;
                    assign sum_last = d_o;
                end
            end
        end

        if (FW > WIDTH) begin : g_ovf
            assign ovf = |sum_last[FW-1:WIDTH];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    assign out_valid = v_last;
    assign z_full    = sum_last;
    assign z         = (SAT_MODE == SAT_SAT && ovf) ? '1
                                                    : sum_last[WIDTH-1:0];

endmodule
